// File: rtl/rhs_cfg_pkg.sv
// rhs_cfg_pkg: shared definitions for the RHS AXI4-Lite configuration block.
//   - register byte offsets, per-register implemented-bit masks
//   - config field widths
//   - AXI response encodings and the write/read FSM state types
//   - helpers for byte-strobe merging and mask lookup
package rhs_cfg_pkg;

    localparam int NUM_REGS = 8;

    localparam logic [7:0] REG_CTRL      = 8'h00;
    localparam logic [7:0] REG_STIM_MAG  = 8'h04;
    localparam logic [7:0] REG_PKT_LEN   = 8'h08;
    localparam logic [7:0] REG_ZCHECK    = 8'h0C;
    localparam logic [7:0] REG_STIM_SEL  = 8'h10;
    localparam logic [7:0] REG_PULSE_W   = 8'h14;
    localparam logic [7:0] REG_IPD       = 8'h18;
    localparam logic [7:0] REG_NUM_PULSE = 8'h1C;
    localparam logic [7:0] REG_STATUS    = 8'h20;

    localparam int CTRL_W      = 32;
    localparam int STIM_MAG_W  = 32;
    localparam int PKT_LEN_W   = 16;
    localparam int ZCHECK_W    = 10;
    localparam int STIM_SEL_W  = 26;
    localparam int PULSE_W_W   = 16;
    localparam int IPD_W       = 16;
    localparam int NUM_PULSE_W = 11;

    localparam logic [31:0] MASK_CTRL      = 32'hFFFF_FFFF;
    localparam logic [31:0] MASK_STIM_MAG  = 32'hFFFF_FFFF;
    localparam logic [31:0] MASK_PKT_LEN   = 32'h0000_FFFF;
    localparam logic [31:0] MASK_ZCHECK    = 32'h0000_03FF;
    localparam logic [31:0] MASK_STIM_SEL  = 32'h03FF_FFFF;
    localparam logic [31:0] MASK_PULSE_W   = 32'h0000_FFFF;
    localparam logic [31:0] MASK_IPD       = 32'h0000_FFFF;
    localparam logic [31:0] MASK_NUM_PULSE = 32'h0000_07FF;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_COMMIT = 2'd1,
        W_RESP   = 2'd2
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    function automatic logic [31:0] reg_mask(input logic [2:0] idx);
        case (idx)
            3'd0:    return MASK_CTRL;
            3'd1:    return MASK_STIM_MAG;
            3'd2:    return MASK_PKT_LEN;
            3'd3:    return MASK_ZCHECK;
            3'd4:    return MASK_STIM_SEL;
            3'd5:    return MASK_PULSE_W;
            3'd6:    return MASK_IPD;
            default: return MASK_NUM_PULSE;
        endcase
    endfunction

    // Lanes with strobe 0 keep the old byte.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++)
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        return res;
    endfunction

endpackage

// File: rtl/axil_hold_reg.sv
// axil_hold_reg: single-entry capture register with a valid flag.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture d and set valid (channel handshake)
//   clear      : drop valid once the held entry has been consumed
//   d / q      : captured payload
//   valid      : an entry is held
module axil_hold_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/rhs_axil_cfg_regs.sv
// rhs_axil_cfg_regs: AXI4-Lite responder holding the RHS configuration
// registers (0x00-0x1C) and a read-only status word (0x20).
//   rhs_aclk, rhs_areset : clock, synchronous active-high reset
//   s_axi_aw* / w* / b*  : write address / data / response channels
//   s_axi_ar* / r*       : read address / data channels
//   cfg_*                : static configuration buses to the RHS sequencer
//   ctrl_wr_stb          : one-cycle pulse when a write to CTRL commits
//   status_in            : status word, sampled on the AR handshake
module rhs_axil_cfg_regs
    import rhs_cfg_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                  rhs_aclk,
    input  logic                  rhs_areset,
    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_W-1:0]     s_axi_wdata,
    input  logic [DATA_W/8-1:0]   s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_W-1:0]     s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_W-1:0]     s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [CTRL_W-1:0]      cfg_ctrl,
    output logic [STIM_MAG_W-1:0]  cfg_stim_mag,
    output logic [PKT_LEN_W-1:0]   cfg_pkt_len,
    output logic [ZCHECK_W-1:0]    cfg_zcheck,
    output logic [STIM_SEL_W-1:0]  cfg_stim_sel,
    output logic [PULSE_W_W-1:0]   cfg_pulse_w,
    output logic [IPD_W-1:0]       cfg_ipd,
    output logic [NUM_PULSE_W-1:0] cfg_num_pulse,
    output logic                   ctrl_wr_stb,
    input  logic [DATA_W-1:0]      status_in
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int WH_W  = DATA_W + DATA_W/8;
    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(REG_STATUS >> 2);

    wstate_t w_state, w_next;
    rstate_t r_state, r_next;

    logic              ready_en;   // holds the ready outputs low through reset
    logic              aw_hs, w_hs, ar_hs;
    logic              aw_held, w_held;
    logic [ADDR_W-1:0] aw_q;
    logic [WH_W-1:0]   w_q;
    logic [IDX_W-1:0]  widx, ridx;
    logic [31:0]       regs [NUM_REGS];
    logic [31:0]       rd_word;
    resp_t             rd_resp;

    logic unused_bits;
    assign unused_bits = ^{s_axi_awprot, aw_q[1:0], s_axi_araddr[1:0]};

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid  && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign widx  = aw_q[ADDR_W-1:2];
    assign ridx  = s_axi_araddr[ADDR_W-1:2];

    axil_hold_reg #(.W(ADDR_W)) u_aw_hold (
        .clk(rhs_aclk), .rst(rhs_areset), .load(aw_hs),
        .clear(w_state == W_COMMIT), .d(s_axi_awaddr), .q(aw_q), .valid(aw_held)
    );

    axil_hold_reg #(.W(WH_W)) u_w_hold (
        .clk(rhs_aclk), .rst(rhs_areset), .load(w_hs),
        .clear(w_state == W_COMMIT), .d({s_axi_wstrb, s_axi_wdata}), .q(w_q), .valid(w_held)
    );

    always_ff @(posedge rhs_aclk) begin
        if (rhs_areset) ready_en <= 1'b0;
        else            ready_en <= 1'b1;
    end

    // ---------------- write FSM ----------------
    always_ff @(posedge rhs_aclk) begin
        if (rhs_areset) w_state <= W_IDLE;
        else            w_state <= w_next;
    end

    // A handshake this cycle counts as held, so commit follows the later
    // of the two handshakes by exactly one cycle.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:   if ((aw_held || aw_hs) && (w_held || w_hs)) w_next = W_COMMIT;
            W_COMMIT: w_next = W_RESP;
            W_RESP:   if (s_axi_bready) w_next = W_IDLE;
            default:  w_next = W_IDLE;
        endcase
    end

    always_comb begin
        s_axi_awready = ready_en && (w_state == W_IDLE) && !aw_held;
        s_axi_wready  = ready_en && (w_state == W_IDLE) && !w_held;
        s_axi_bvalid  = (w_state == W_RESP);
    end

    // Register update, B response and CTRL strobe all land on the commit
    // edge, so cfg_* and ctrl_wr_stb become visible together.
    always_ff @(posedge rhs_aclk) begin
        if (rhs_areset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            s_axi_bresp <= RESP_OKAY;
            ctrl_wr_stb <= 1'b0;
        end else if (w_state == W_COMMIT) begin
            ctrl_wr_stb <= (widx == '0);
            if (widx < STATUS_IDX)
                regs[widx[2:0]] <= apply_wstrb(regs[widx[2:0]], w_q[DATA_W-1:0],
                                               w_q[DATA_W +: DATA_W/8])
                                   & reg_mask(widx[2:0]);
            s_axi_bresp <= (widx <= STATUS_IDX) ? RESP_OKAY : RESP_SLVERR;
        end else begin
            ctrl_wr_stb <= 1'b0;
        end
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge rhs_aclk) begin
        if (rhs_areset) r_state <= R_IDLE;
        else            r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (s_axi_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi_arready = ready_en && (r_state == R_IDLE);
        s_axi_rvalid  = (r_state == R_DATA);
    end

    always_comb begin
        rd_word = '0;
        rd_resp = RESP_OKAY;
        if (ridx < STATUS_IDX)       rd_word = regs[ridx[2:0]];
        else if (ridx == STATUS_IDX) rd_word = status_in;
        else                         rd_resp = RESP_SLVERR;
    end

    // Sampling registers (not the commit result) gives old-value semantics
    // when the AR handshake coincides with a commit.
    always_ff @(posedge rhs_aclk) begin
        if (rhs_areset) begin
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_OKAY;
        end else if (ar_hs) begin
            s_axi_rdata <= rd_word;
            s_axi_rresp <= rd_resp;
        end
    end

    assign cfg_ctrl      = regs[0];
    assign cfg_stim_mag  = regs[1];
    assign cfg_pkt_len   = regs[2][PKT_LEN_W-1:0];
    assign cfg_zcheck    = regs[3][ZCHECK_W-1:0];
    assign cfg_stim_sel  = regs[4][STIM_SEL_W-1:0];
    assign cfg_pulse_w   = regs[5][PULSE_W_W-1:0];
    assign cfg_ipd       = regs[6][IPD_W-1:0];
    assign cfg_num_pulse = regs[7][NUM_PULSE_W-1:0];

endmodule

// File: doc/rhs_axil_cfg_regs.md
# rhs_axil_cfg_regs

AXI4-Lite responder that terminates the RHS controller's configuration port on the PS-facing side. It holds the stimulation, packet-length, impedance-check and control registers that software (or the AXI VIP master in simulation) writes, and drives them as static configuration buses into the RHS sequencer. It also returns a read-only status word. It is the slave end of the register traffic issued by the RHS bring-up sequence, and sits between the AXI interconnect and the RHS command/stim engine.

## Interface
- ADDR_W, 6: AXI address width in bits. Byte addressed; bits [1:0] are ignored.
- DATA_W, 32: AXI data width in bits. Fixed at 32.
- rhs_aclk  in  1  sole clock.
- rhs_areset  in  1  reset. Synchronous and active-high.
- s_axi_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  write address channel. awprot is accepted and ignored.
- s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
- s_axi_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  read address channel.
- s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
- cfg_ctrl  out  32  register 0x00.
- cfg_stim_mag  out  32  register 0x04: {pos_mag, pos_trim, neg_mag, neg_trim}, 8 bits each.
- cfg_pkt_len  out  16  register 0x08 [15:0].
- cfg_zcheck  out  10  register 0x0C: [9:8] scale, [7:0] cycle.
- cfg_stim_sel  out  26  register 0x10: [25:10] mask, [9] polarity, [8] mono/bi, [7:4] ch_n, [3:0] ch_p.
- cfg_pulse_w  out  16  register 0x14 [15:0].
- cfg_ipd  out  16  register 0x18 [15:0].
- cfg_num_pulse  out  11  register 0x1C [10:0]. Bit 10 means infinite.
- ctrl_wr_stb  out  1  one-cycle pulse when a write to 0x00 commits.
- status_in  in  32  sampled into the read path at 0x20. Read-only.

## Operation
- Register map, word offsets 0x00–0x1C as listed above, 0x20 STATUS.
- Unimplemented bits read 0 and are not stored.
- Writes:
  - Honour WSTRB per byte lane; lanes with strobe 0 are left unchanged.
  - A write to 0x20 is accepted, has no effect, and returns OKAY.
  - A write to address ≥ 0x24 returns SLVERR and changes nothing.
- Reads:
  - 0x00–0x1C return the stored, masked value.
  - 0x20 returns status_in as sampled on the AR handshake cycle.
  - Address ≥ 0x24 returns rdata 0 with SLVERR.
- Write FSM, states W_IDLE → W_COMMIT → W_RESP:
  - W_IDLE: AW and W are each latched independently into holding registers when they handshake, in either order or in the same cycle.
  - Once both are held, the FSM goes to W_COMMIT.
  - W_COMMIT (one cycle): updates the target register. Pulses ctrl_wr_stb if the address is 0x00. Goes to W_RESP.
  - W_RESP: bvalid is high until bready is high, then the FSM returns to W_IDLE.
- Read FSM, states R_IDLE → R_DATA:
  - On the AR handshake, rdata and rresp are registered and the FSM goes to R_DATA.
  - R_DATA: rvalid is high until rready is high.

## Timing
- Reset values: every cfg_* output is 0, ctrl_wr_stb 0, all ready/valid outputs 0, bresp/rresp 0, rdata 0.
- awready, wready and arready rise on the first cycle after rhs_areset is deasserted.
- awready is high only while no AW address is held and the write FSM is in W_IDLE. wready follows the same rule for W data.
- arready equals (read FSM in R_IDLE).
- Write latency: from the cycle both AW and W have been handshaken, the register updates 1 cycle later and bvalid rises 2 cycles later. cfg_* is visible on the same edge as ctrl_wr_stb.
- Read latency: rvalid rises on the cycle after the AR handshake.
- Only one outstanding transaction per direction. The read and write paths operate concurrently.
- Same-address collision: a read whose AR handshake coincides with W_COMMIT returns the old value.
- Valid/data are never withdrawn before the corresponding ready handshake.
- A reset asserted mid-transaction aborts it immediately and restores the reset values above. No response is issued for the aborted transaction.

## Structure
- A shared package rhs_cfg_pkg holds:
  - the register offset localparams (REG_CTRL … REG_STATUS);
  - per-register valid-bit masks;
  - the field-slice widths;
  - the resp_t encodings OKAY=2'b00 and SLVERR=2'b10.
- The write and read FSMs live in this module.
- One natural sub-module is axil_hold_reg: a single-entry capture register with valid flag, instantiated once for AW and once for W.

## Test plan
- Write 0x80FF80FF to 0x04, then read it back: rdata = 0x80FF80FF, OKAY, and cfg_stim_mag matches.
- Write 0x010007F0 to 0x10: cfg_stim_sel = 26'h10007F0. Then write 0xFFFFFFFF to 0x1C and read it back: result is 0x7FF, because of masking.
- Present W 3 cycles before AW when writing 0x29 to 0x00: ctrl_wr_stb pulses for exactly 1 cycle, bvalid rises 2 cycles after AW, and cfg_ctrl = 0x29.
- Write 0xAABBCCDD to 0x08 with wstrb = 4'b0001 over an existing 0x00000002: result is 0x000000DD. Write to 0x24: SLVERR with no state change. Read 0x30: rdata 0 with SLVERR.
- Hold bready and rready low for 10 cycles: bvalid and rvalid stay high, awready and arready stay low, and a second AW is not accepted until the B handshake.
- Assert rhs_areset while bvalid is high: the next cycle all cfg_* = 0 and bvalid = 0. Then drive status_in = 0xDEADBEEF and read 0x20: returns 0xDEADBEEF.
